io_bus_ctrl: RTL
================

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 Parameter WAIT_CYC, default 1, meaning: extra ACCESS cycles beyond the first (legal range 0..15).
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port isReset_n  input  1  asynchronous, active-low reset.
REQ-004 Port req  input  1  CPU IO request; sampled only in IDLE.
REQ-005 Port we  input  1  1 = write, 0 = read; latched with req.
REQ-006 Port addr  input  4  addr[1:0] = peripheral index 0..3, addr[3:2] must be 0.
REQ-007 Port wdata  input  16  CPU write data; latched with req.
REQ-008 Port rdata  output  16  read data returned to CPU.
REQ-009 Port ack  output  1  one-cycle completion pulse.
REQ-010 Port err  output  1  error flag, valid only while ack=1.
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Port cs  output  4  one-hot peripheral chip selects (isCS of each peripheral).
REQ-013 Port isW  output  1  shared write strobe to peripherals.
REQ-014 Port dR  output  16  shared write data to peripherals.
REQ-015 Port dW  input  16  shared tri-state read bus from peripherals.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE; encoding free, no other reachable states.
REQ-017 IDLE with req=1 and addr[3:2]=0: latch we, addr[1:0], wdata; next state ACCESS; wait counter loaded with WAIT_CYC.
REQ-018 IDLE with req=1 and addr[3:2]!=0: next state DONE with err latched 1; cs never asserted for that transaction.
REQ-019 IDLE with req=0: remain IDLE; all peripheral outputs inactive.
REQ-020 ACCESS: cs = one-hot of latched index, isW = latched we, dR = latched wdata, all constant for exactly WAIT_CYC+1 cycles.
REQ-021 ACCESS: counter decrements each cycle; at counter=0 next state DONE.
REQ-022 Read transaction: rdata loaded from dW on the rising edge that leaves ACCESS; rdata holds until next read completes.
REQ-023 Write transaction: rdata unchanged.
REQ-024 Peripherals capture on negedge clk; cs/isW/dR therefore change only on rising edges and are stable across at least one falling edge.
REQ-025 DONE: ack=1 for exactly one cycle, err = latched error (0 for valid access), cs=0, isW=0; next state IDLE unconditionally.
REQ-026 Latency: req sampled at edge N -> ack high during cycle N+WAIT_CYC+2 (valid access), N+1 (error).
REQ-027 Outside ACCESS: cs=4'b0000, isW=0, dR=16'h0000.
REQ-028 req, we, addr, wdata changes while busy=1 are ignored; no queueing.
REQ-029 req held high continuously: new transaction accepted in the IDLE cycle following each ack (one idle cycle minimum between transactions).
REQ-030 err=0 whenever ack=0.

Reset
REQ-031 isReset_n=0 forces, asynchronously: state IDLE, counter 0, cs=0, isW=0, dR=0, rdata=0, ack=0, err=0, busy=0.
REQ-032 Reset mid-transaction aborts it with no ack; after release FSM waits in IDLE for a fresh req.
REQ-033 First req accepted on the first rising edge where isReset_n=1.

Verification
REQ-034 WAIT_CYC=1, write addr=4'h0, wdata=16'hA5A5 at edge 0 -> cs=0001, isW=1, dR=A5A5 cycles 1-2; ack=1, err=0 cycle 3; LED register reads A5A5.
REQ-035 WAIT_CYC=1, read addr=4'h2, peripheral drives dW=16'h1234 -> cs=0100, isW=0 cycles 1-2; cycle 3 ack=1, rdata=1234.
REQ-036 Request addr=4'h5 -> cs stays 0000; ack=1, err=1 in cycle 1; busy low in cycle 2.
REQ-037 isReset_n pulled low during ACCESS -> cs, isW, ack, busy drop immediately; no ack after release; next req completes normally.
REQ-038 WAIT_CYC=0, req held high for writes to addr 0 then 1 -> each ACCESS lasts 1 cycle, acks in cycles 2 and 5, cs=0001 then 0010.
REQ-039 req toggled and addr/wdata changed during ACCESS -> dR, cs unchanged; exactly one ack per accepted request.

Source files
------------

// File: rtl/io_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// io_bus_ctrl_if : bundle of CPU-side and peripheral-side signals of the IO
// bus controller.
//
//   CPU side       : req, we, addr[3:0], wdata[15:0]  (to controller)
//                    rdata[15:0], ack, err, busy      (from controller)
//   Peripheral side: cs[3:0], isW, dR[15:0]           (from controller)
//                    dW[15:0]                         (to controller)
//
//   slave  modport : the controller itself
//   master modport : the environment (CPU plus peripherals)
// ---------------------------------------------------------------------------
interface io_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic [3:0]  cs;
  logic        isW;
  logic [15:0] dR;
  logic [15:0] dW;

  modport slave (
    input  req, we, addr, wdata, dW,
    output rdata, ack, err, busy, cs, isW, dR
  );

  modport master (
    output req, we, addr, wdata, dW,
    input  rdata, ack, err, busy, cs, isW, dR
  );
endinterface

// File: rtl/io_bus_ctrl.sv
// ---------------------------------------------------------------------------
// io_bus_ctrl : single-outstanding IO bus controller between a CPU and four
// peripherals sharing one write strobe and one data bus in each direction.
//
// A request is sampled only while idle. A valid address (addr[3:2] == 0)
// opens an ACCESS phase of WAIT_CYC+1 cycles driving cs/isW/dR, followed by a
// one-cycle DONE with ack. An invalid address skips ACCESS and goes straight
// to DONE with err. Every output is a flop loaded from the next-state view, so
// peripheral-facing signals only move on rising edges and are stable across
// the falling edge on which peripherals capture.
//
// Ports:
//   clk       : system clock, rising-edge active
//   isReset_n : asynchronous active-low reset
//   bus       : io_bus_ctrl_if.slave (CPU and peripheral signals)
// ---------------------------------------------------------------------------
module io_bus_ctrl #(
  parameter int unsigned WAIT_CYC = 1  // extra ACCESS cycles, 0..15
) (
  input  logic          clk,
  input  logic          isReset_n,
  io_bus_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic [3:0]  cnt_q,     cnt_d;
  logic        we_q,      we_d;
  logic [1:0]  idx_q,     idx_d;
  logic [15:0] wdata_q,   wdata_d;
  logic        err_lat_q, err_lat_d;
  logic [3:0]  cs_q,      cs_d;
  logic        is_w_q,    is_w_d;
  logic [15:0] d_r_q,     d_r_d;
  logic [15:0] rdata_q,   rdata_d;
  logic        ack_q,     ack_d;
  logic        err_q,     err_d;
  logic        busy_q,    busy_d;

  // Decode a peripheral index into its chip-select line.
  function automatic logic [3:0] idx_to_cs(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = 4'b0001;
      2'd1:    sel = 4'b0010;
      2'd2:    sel = 4'b0100;
      2'd3:    sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Next-state, transaction latches and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_lat_d = err_lat_q;
    rdata_d   = rdata_q;
    cs_d      = 4'b0000;
    is_w_d    = 1'b0;
    d_r_d     = 16'h0000;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (bus.addr[3:2] == 2'b00) begin
            state_d   = ST_ACCESS;
            cnt_d     = 4'(WAIT_CYC);
            we_d      = bus.we;
            idx_d     = bus.addr[1:0];
            wdata_d   = bus.wdata;
            err_lat_d = 1'b0;
          end else begin
            // Bad address: no peripheral is touched, report on the next cycle.
            state_d   = ST_DONE;
            err_lat_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          // Read data is taken on the edge that closes the access window.
          if (!we_q) begin
            rdata_d = bus.dW;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from where the FSM is going, then registered.
    if (state_d == ST_ACCESS) begin
      cs_d   = idx_to_cs(idx_d);
      is_w_d = we_d;
      d_r_d  = wdata_d;
    end else begin
      cs_d   = 4'b0000;
      is_w_d = 1'b0;
      d_r_d  = 16'h0000;
    end

    if (state_d == ST_DONE) begin
      ack_d = 1'b1;
      err_d = err_lat_d;
    end else begin
      ack_d = 1'b0;
      err_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, transaction latches and registered outputs.
  always_ff @(posedge clk or negedge isReset_n) begin
    if (!isReset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      idx_q     <= 2'd0;
      wdata_q   <= 16'h0000;
      err_lat_q <= 1'b0;
      cs_q      <= 4'b0000;
      is_w_q    <= 1'b0;
      d_r_q     <= 16'h0000;
      rdata_q   <= 16'h0000;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      err_lat_q <= err_lat_d;
      cs_q      <= cs_d;
      is_w_q    <= is_w_d;
      d_r_q     <= d_r_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.cs    = cs_q;
  assign bus.isW   = is_w_q;
  assign bus.dR    = d_r_q;
  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule
